adder_result_sink: RTL
======================

Name: adder_result_sink

Overview:
Downstream stage of the adder handshake block. Consumes signed sum results over a valid/ready port and buffers them in a small FIFO. Accumulates every BLOCK results into a running signed sum and presents each block total on a second valid/ready port for the scoreboard or next datapath stage.

Parameters:
WIDTH, 8, bit width of incoming signed results (two's complement)
DEPTH, 4, FIFO entries (power of two, >= 2)
BLOCK, 4, results summed per emitted total (>= 1)
ACC_W, 10, accumulator / out_sum width (>= WIDTH)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
in_data  in  WIDTH  signed result from the adder stage
in_valid  in  1  upstream result valid
in_ready  out  1  sink can accept in_data this cycle
out_sum  out  ACC_W  signed block total
out_ovf  out  1  block total saturated; qualified by out_valid
out_valid  out  1  out_sum/out_ovf valid
out_ready  in  1  downstream accepts out_sum
fill_level  out  $clog2(DEPTH+1)  current FIFO occupancy

Behaviour:
- Reset (rst=1 at a rising edge): FIFO empty, fill_level=0, acc=0, blk_cnt=0, out_sum=0, out_ovf=0, out_valid=0, state=IDLE. Applies mid-block and mid-SEND; buffered data is discarded.
- in_ready = (state != IDLE) && (fill_level != DEPTH), combinational from registered state. A push occurs on a rising edge with in_valid && in_ready. No push-through when full, even if a pop happens in the same cycle.
- FIFO: circular, registered write/read pointers with wrap at DEPTH. Simultaneous push and pop leave fill_level unchanged. in_data is sign-extended to ACC_W on pop.
- FSM:
  - IDLE: lasts one cycle after reset, then goes to ACCUM.
  - ACCUM: each cycle with fill_level != 0, pop the head and set acc <= sat(acc + head), blk_cnt++. When the pop makes blk_cnt == BLOCK, go to SEND. out_valid=1 from the next cycle, out_sum = final acc, out_ovf = sticky saturation flag of the block.
  - SEND: no pops; FIFO keeps accepting pushes. While out_ready=0, out_sum, out_ovf and out_valid are held stable. On out_valid && out_ready at an edge: out_valid<=0, acc<=0, blk_cnt<=0, ovf<=0, go to ACCUM.
- Latency: a word pushed at edge t can be popped at edge t+1 at the earliest. With BLOCK=4 and back-to-back pushes starting at edge t, out_valid rises after edge t+4.
- Saturation: the sum is computed at ACC_W+1 bits, then clamped to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. Any clamp sets the sticky ovf bit for the current block.

Optional Feature:
RESULT_SINK_SAT_EN
- Defined: saturating accumulation and sticky out_ovf as described above.
- Undefined: acc wraps modulo 2^ACC_W, out_ovf is tied to 0, and the saturation logic is removed. All other timing is identical.

Test Plan:
- Basic block (defaults): push 10, 20, -5, 7 back-to-back with out_ready=1 -> one transfer with out_sum=32, out_ovf=0, no further out_valid.
- Backpressure/full: out_ready=0, push 12 values 1..12 with in_valid held high -> first block total 10 is held stable. Pushes 5..8 fill the FIFO and then in_ready=0 with fill_level=4. Release out_ready -> totals 10, 26, 42 emitted in order; no value lost or duplicated.
- Saturation (ACC_W=9, macro defined): push 127, 127, 10, 0 -> out_sum=255, out_ovf=1. Next block 1, 1, 1, 1 -> out_sum=4, out_ovf=0.
- Wrap (ACC_W=9, macro undefined): same stimulus -> out_sum=-248, out_ovf=0.
- Negative clamp (ACC_W=9, macro defined): push -128 four times -> out_sum=-256, out_ovf=1.
- Reset mid-operation: push 3 values, assert rst for one cycle, then push 1, 2, 3, 4 -> first output is 10. fill_level=0 and out_valid=0 in the cycle after reset. in_ready=0 during the IDLE cycle.

Source files
------------

// File: rtl/adder_result_sink.sv
// adder_result_sink: buffers signed adder results in a small circular FIFO,
// sums every BLOCK of them and offers each block total on a valid/ready port.
// Optional feature macro: RESULT_SINK_SAT_EN
//   defined   -> saturating accumulation with sticky out_ovf per block
//   undefined -> accumulator wraps modulo 2^ACC_W, out_ovf tied low
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | single settling cycle after reset, input port not ready
// S_ACCUM | pop one FIFO word per cycle into the block accumulator
// S_SEND  | block total presented, waiting for out_ready; no pops
module adder_result_sink #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int BLOCK = 4,
  parameter int ACC_W = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [ACC_W-1:0]           out_sum,
  output logic                       out_ovf,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] fill_level
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int FILL_W = $clog2(DEPTH+1);
  localparam int CNT_W  = $clog2(BLOCK+1);
  localparam logic [FILL_W-1:0] DEPTH_C = FILL_W'(DEPTH);
  localparam logic [CNT_W-1:0]  BLOCK_C = CNT_W'(BLOCK);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_SEND} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [WIDTH-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [FILL_W-1:0]    fill_q, fill_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0]     blk_cnt_q, blk_cnt_d;
  logic [ACC_W-1:0]     out_sum_q, out_sum_d;
  logic                 out_valid_q, out_valid_d;
  logic                 push, pop;
  logic [ACC_W-1:0]     acc_next;
  logic                 clamp;

  assign in_ready   = (state_q != S_IDLE) && (fill_q != DEPTH_C);
  assign push       = in_valid && in_ready;
  assign pop        = (state_q == S_ACCUM) && (fill_q != '0);
  assign fill_level = fill_q;
  assign out_sum    = out_sum_q;
  assign out_valid  = out_valid_q;

`ifdef RESULT_SINK_SAT_EN
  logic               ovf_q, ovf_d;
  logic signed [ACC_W:0] head_ext, acc_ext, sum_full;
  logic               pos_ovf, neg_ovf;

  // Add one bit wider than the accumulator, then clamp to the signed range.
  always_comb begin
    head_ext = (ACC_W+1)'($signed(mem_q[rd_ptr_q]));
    acc_ext  = (ACC_W+1)'($signed(acc_q));
    sum_full = acc_ext + head_ext;
    pos_ovf  = ~sum_full[ACC_W] &  sum_full[ACC_W-1];
    neg_ovf  =  sum_full[ACC_W] & ~sum_full[ACC_W-1];
    clamp    = pos_ovf | neg_ovf;
    if (pos_ovf)      acc_next = {1'b0, {(ACC_W-1){1'b1}}};
    else if (neg_ovf) acc_next = {1'b1, {(ACC_W-1){1'b0}}};
    else              acc_next = sum_full[ACC_W-1:0];
  end

  assign out_ovf = ovf_q;
`else
  logic [ACC_W-1:0] head_w;

  // Plain modulo-2^ACC_W accumulation.
  always_comb begin
    head_w   = ACC_W'($signed(mem_q[rd_ptr_q]));
    acc_next = acc_q + head_w;
    clamp    = 1'b0;
  end

  assign out_ovf = 1'b0;
`endif

  // FIFO storage and pointers; full blocks pushes even when a pop coincides.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   fill_d = fill_q + FILL_W'(1);
      2'b01:   fill_d = fill_q - FILL_W'(1);
      default: fill_d = fill_q;
    endcase
  end

  // Block accumulation FSM: next state, accumulator and output register.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    blk_cnt_d   = blk_cnt_q;
    out_sum_d   = out_sum_q;
    out_valid_d = out_valid_q;
`ifdef RESULT_SINK_SAT_EN
    ovf_d       = ovf_q;
`endif
    case (state_q)
      S_IDLE: state_d = S_ACCUM;
      S_ACCUM: begin
        if (pop) begin
          acc_d     = acc_next;
          blk_cnt_d = blk_cnt_q + CNT_W'(1);
`ifdef RESULT_SINK_SAT_EN
          ovf_d     = ovf_q | clamp;
`endif
          if (blk_cnt_q + CNT_W'(1) == BLOCK_C) begin
            state_d     = S_SEND;
            out_valid_d = 1'b1;
            out_sum_d   = acc_next;
          end
        end
      end
      S_SEND: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          acc_d       = '0;
          blk_cnt_d   = '0;
`ifdef RESULT_SINK_SAT_EN
          ovf_d       = 1'b0;
`endif
          state_d     = S_ACCUM;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fill_q      <= '0;
      acc_q       <= '0;
      blk_cnt_q   <= '0;
      out_sum_q   <= '0;
      out_valid_q <= 1'b0;
`ifdef RESULT_SINK_SAT_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fill_q      <= fill_d;
      acc_q       <= acc_d;
      blk_cnt_q   <= blk_cnt_d;
      out_sum_q   <= out_sum_d;
      out_valid_q <= out_valid_d;
`ifdef RESULT_SINK_SAT_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  // FIFO contents need no reset; occupancy gates every read.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
